// File: rtl/text_console_writer.sv
// text_console_writer
//   Bus initiator that turns a stream of character bytes into writes to the
//   COLS x ROWS text buffer owned by the video block. Keeps a cursor, handles
//   CR / LF / BS / FF, and scrolls the screen up one row by copying the buffer
//   over the same bus when the cursor runs off the bottom.
//
// Ports
//   clk_25mhz, rst_i        clock, asynchronous active-low reset
//   ch_i, ch_valid_i        character byte in, valid
//   ch_ready_o              high in IDLE; a byte is taken on valid & ready
//   adr_o, dat_o, sel_o,
//   we_o, stb_o             bus request (byte address, replicated write data,
//                           one-hot lane select, write enable, strobe)
//   ack_i, dat_i            bus acknowledge, registered read data
//   busy_o                  high whenever the FSM is not in IDLE
//   cur_col_o, cur_row_o    registered cursor position
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a byte; control codes that touch only the cursor
//         | are handled here in one cycle
// PUT     | writing the accepted character at the cursor
// ADV     | moving the cursor after a character write (may wrap/scroll)
// SCR_RD  | scroll: reading source cell ptr
// SCR_CAP | scroll: capturing the read byte (responder registers data)
// SCR_WR  | scroll: writing captured byte one row up (ptr - COLS)
// CLR     | scroll: blanking the last row
// HOME    | form feed: blanking the whole screen, then cursor to (0,0)

module text_console_writer #(
  parameter int unsigned COLS  = 80,
  parameter int unsigned ROWS  = 60,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic        clk_25mhz,
  input  logic        rst_i,
  input  logic [7:0]  ch_i,
  input  logic        ch_valid_i,
  output logic        ch_ready_o,
  output logic [12:0] adr_o,
  output logic [31:0] dat_o,
  output logic [3:0]  sel_o,
  output logic        we_o,
  output logic        stb_o,
  input  logic        ack_i,
  input  logic [31:0] dat_i,
  output logic        busy_o,
  output logic [6:0]  cur_col_o,
  output logic [5:0]  cur_row_o
);

  localparam logic [12:0] COLS_A   = 13'(COLS);
  localparam logic [12:0] LAST     = 13'(COLS * ROWS - 1);
  localparam logic [12:0] CLR_BASE = 13'((ROWS - 1) * COLS);
  localparam logic [6:0]  COL_MAX  = 7'(COLS - 1);
  localparam logic [5:0]  ROW_MAX  = 6'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE, PUT, ADV, SCR_RD, SCR_CAP, SCR_WR, CLR, HOME
  } state_t;

  state_t      state, state_nxt;
  logic [6:0]  col, col_nxt;
  logic [5:0]  row, row_nxt;
  logic [12:0] ptr, ptr_nxt;
  logic [7:0]  data_q, data_nxt;
  logic [12:0] cur_adr;
  logic [7:0]  rd_byte;

  // row*COLS + col; for COLS=80 this is row*64 + row*16 + col
  assign cur_adr = 13'(row) * COLS_A + 13'(col);

  always_ff @(posedge clk_25mhz or negedge rst_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      col    <= '0;
      row    <= '0;
      ptr    <= '0;
      data_q <= '0;
    end else begin
      state  <= state_nxt;
      col    <= col_nxt;
      row    <= row_nxt;
      ptr    <= ptr_nxt;
      data_q <= data_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    col_nxt    = col;
    row_nxt    = row;
    ptr_nxt    = ptr;
    data_nxt   = data_q;
    stb_o      = 1'b0;
    we_o       = 1'b0;
    adr_o      = '0;
    sel_o      = '0;
    rd_byte    = '0;
    ch_ready_o = (state == IDLE);
    busy_o     = (state != IDLE);

    // bus request is a pure function of registered state, so it is stable
    // for the whole strobe and drops the instant reset clears the state
    unique case (state)
      PUT:             begin stb_o = 1'b1; we_o = 1'b1; adr_o = cur_adr; end
      SCR_RD:          begin stb_o = 1'b1; adr_o = ptr; end
      SCR_CAP:         adr_o = ptr;
      SCR_WR:          begin stb_o = 1'b1; we_o = 1'b1; adr_o = ptr - COLS_A; end
      CLR, HOME:       begin stb_o = 1'b1; we_o = 1'b1; adr_o = ptr; end
      default:         adr_o = '0;
    endcase

    if (stb_o) sel_o = 4'b0001 << adr_o[1:0];
    dat_o = (state == CLR || state == HOME) ? {4{BLANK}} : {4{data_q}};

    unique case (adr_o[1:0])
      2'd0: rd_byte = dat_i[7:0];
      2'd1: rd_byte = dat_i[15:8];
      2'd2: rd_byte = dat_i[23:16];
      default: rd_byte = dat_i[31:24];
    endcase

    unique case (state)
      IDLE: begin
        if (ch_valid_i) begin
          unique case (ch_i)
            8'h0D: col_nxt = '0;
            8'h0A: begin
              col_nxt = '0;
              if (row < ROW_MAX) begin
                row_nxt = row + 6'd1;
              end else begin
                state_nxt = SCR_RD;
                ptr_nxt   = COLS_A;
              end
            end
            8'h08: if (col != '0) col_nxt = col - 7'd1;
            8'h0C: begin
              state_nxt = HOME;
              ptr_nxt   = '0;
            end
            default: begin
              data_nxt  = ch_i;
              state_nxt = PUT;
            end
          endcase
        end
      end
      PUT: if (ack_i) state_nxt = ADV;
      ADV: begin
        if (col < COL_MAX) begin
          col_nxt   = col + 7'd1;
          state_nxt = IDLE;
        end else begin
          col_nxt = '0;
          if (row < ROW_MAX) begin
            row_nxt   = row + 6'd1;
            state_nxt = IDLE;
          end else begin
            state_nxt = SCR_RD;
            ptr_nxt   = COLS_A;
          end
        end
      end
      SCR_RD: if (ack_i) state_nxt = SCR_CAP;
      SCR_CAP: begin
        data_nxt  = rd_byte;
        state_nxt = SCR_WR;
      end
      SCR_WR: begin
        if (ack_i) begin
          if (ptr == LAST) begin
            state_nxt = CLR;
            ptr_nxt   = CLR_BASE;
          end else begin
            state_nxt = SCR_RD;
            ptr_nxt   = ptr + 13'd1;
          end
        end
      end
      CLR: begin
        if (ack_i) begin
          if (ptr == LAST) state_nxt = IDLE;
          else             ptr_nxt   = ptr + 13'd1;
        end
      end
      HOME: begin
        if (ack_i) begin
          if (ptr == LAST) begin
            state_nxt = IDLE;
            col_nxt   = '0;
            row_nxt   = '0;
          end else begin
            ptr_nxt = ptr + 13'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cur_col_o = col;
  assign cur_row_o = row;

endmodule
